cpu_control_fsm: RTL and testbench

//  Multi-cycle sequencer directly upstream of the CPU datapath. Drives every datapath control strobe.

---
 rtl/cpu_control_fsm_if.sv | 20 ++
 rtl/cpu_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Memory/data-bus handshake between the control sequencer (master) and the memory side (slave).
interface cpu_control_fsm_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic             DataBus_En;
    logic             Valid;
    logic [WIDTH-1:0] data_in;

    modport master (
        output mem_req, mem_we, DataBus_En,
        input  Valid, data_in
    );

    modport slave (
        input  mem_req, mem_we, DataBus_En,
        output Valid, data_in
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/memory/writeback with a
// memory-wait watchdog and sticky halt/timeout traps.
module cpu_control_fsm #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_control_fsm_if.master     bus,
    output logic                  regEn,
    output logic                  increment,
    output logic                  Branch_En,
    output logic                  fetch,
    output logic                  store_en,
    output logic                  wrData,
    output logic                  wrAdd,
    output logic                  pc_load,
    output logic [5:0]            opcode,
    output logic [4:0]            oppA,
    output logic [4:0]            oppB,
    output logic [WIDTH-1:0]      literal,
    output logic                  halted,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_FETCH, S_IMEM, S_DECODE, S_EXEC, S_WB, S_MEM, S_HALTED, S_TRAP
    } state_t;

    typedef struct packed {
        logic fetch;
        logic wradd;
        logic wrdata;
        logic branch;
        logic pcload;
        logic req;
        logic we;
        logic dbus;
        logic regen;
    } strobes_t;

    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [3:0] WAIT_MAX = 4'(TIMEOUT - 1);

    state_t      state;
    state_t      nxt;
    strobes_t    str;
    logic [31:0] ir;
    logic [3:0]  wait_cnt;
    logic        waiting;
    logic        load_ack;

    // Moore strobes for the state being entered, so they register in step with the state.
    function automatic strobes_t strobes_for(state_t s, logic [5:0] op);
        strobes_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.fetch = 1'b1;
                o.wradd = 1'b1;
            end
            S_IMEM:  o.req = 1'b1;
            S_EXEC: begin
                if (op != OP_HALT) begin
                    case (op[5:4])
                        2'b01:   o.wradd = 1'b1;
                        2'b10: begin
                            o.branch = 1'b1;
                            o.wradd  = 1'b1;
                            o.pcload = 1'b1;
                        end
                        default: o.wrdata = 1'b1;
                    endcase
                end
            end
            S_WB:    o.regen = 1'b1;
            S_MEM: begin
                o.req  = 1'b1;
                o.we   = op[0];
                o.dbus = op[0];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign waiting = (state == S_IMEM) || (state == S_MEM);

    always_comb begin
        nxt = state;
        case (state)
            // The first FETCH after reset has its strobes still cleared, so it repeats once.
            S_FETCH:  nxt = fetch ? S_IMEM : S_FETCH;
            S_IMEM: begin
                if (bus.Valid)                nxt = S_DECODE;
                else if (wait_cnt == WAIT_MAX) nxt = S_TRAP;
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_HALT) nxt = S_HALTED;
                else begin
                    case (opcode[5:4])
                        2'b01:   nxt = S_MEM;
                        2'b10:   nxt = S_IMEM;
                        default: nxt = S_WB;
                    endcase
                end
            end
            S_WB:     nxt = S_FETCH;
            S_MEM: begin
                if (bus.Valid)                nxt = S_FETCH;
                else if (wait_cnt == WAIT_MAX) nxt = S_TRAP;
            end
            S_HALTED: nxt = S_HALTED;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            str         <= '0;
            ir          <= '0;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= nxt;
            str   <= strobes_for(nxt, opcode);
            if (state == S_IMEM && bus.Valid)
                ir <= bus.data_in[31:0];
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting && !bus.Valid)
                wait_cnt <= wait_cnt + 4'd1;
            if (nxt == S_HALTED)
                halted <= 1'b1;
            if (nxt == S_TRAP)
                timeout_err <= 1'b1;
        end
    end

    // Acknowledge-qualified strobes must land in the Valid cycle itself.
    assign load_ack  = (state == S_MEM) && !opcode[0] && bus.Valid;
    assign increment = (state == S_IMEM) && bus.Valid;
    assign regEn     = str.regen | load_ack;
    assign store_en  = load_ack;

    assign fetch          = str.fetch;
    assign wrAdd          = str.wradd;
    assign wrData         = str.wrdata;
    assign Branch_En      = str.branch;
    assign pc_load        = str.pcload;
    assign bus.mem_req    = str.req;
    assign bus.mem_we     = str.we;
    assign bus.DataBus_En = str.dbus;

    assign opcode  = ir[31:26];
    assign oppA    = ir[25:21];
    assign oppB    = ir[20:16];
    assign literal = {{(WIDTH-16){ir[15]}}, ir[15:0]};

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-cycle strobe vectors and decode fields against hand-derived values.
module tb_cpu_control_fsm;

    localparam logic [12:0] R_EN = 13'h1000;
    localparam logic [12:0] INC  = 13'h0800;
    localparam logic [12:0] BR   = 13'h0400;
    localparam logic [12:0] FET  = 13'h0200;
    localparam logic [12:0] DB   = 13'h0100;
    localparam logic [12:0] ST   = 13'h0080;
    localparam logic [12:0] WD   = 13'h0040;
    localparam logic [12:0] WA   = 13'h0020;
    localparam logic [12:0] PCL  = 13'h0010;
    localparam logic [12:0] REQ  = 13'h0008;
    localparam logic [12:0] WE   = 13'h0004;
    localparam logic [12:0] HLT  = 13'h0002;
    localparam logic [12:0] TO   = 13'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        regEn, increment, Branch_En, fetch, store_en, wrData, wrAdd, pc_load;
    logic [5:0]  opcode;
    logic [4:0]  oppA, oppB;
    logic [31:0] literal;
    logic        halted, timeout_err;
    int          compared   = 0;
    int          mismatched = 0;

    cpu_control_fsm_if #(.WIDTH(32)) bus ();

    cpu_control_fsm #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .regEn(regEn), .increment(increment), .Branch_En(Branch_En), .fetch(fetch),
        .store_en(store_en), .wrData(wrData), .wrAdd(wrAdd), .pc_load(pc_load),
        .opcode(opcode), .oppA(oppA), .oppB(oppB), .literal(literal),
        .halted(halted), .timeout_err(timeout_err)
    );

    wire [12:0] sv = {regEn, increment, Branch_En, fetch, bus.DataBus_En, store_en, wrData,
                      wrAdd, pc_load, bus.mem_req, bus.mem_we, halted, timeout_err};
    wire [47:0] fld = {opcode, oppA, oppB, literal};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the edge that starts the post-reset FETCH cycle.
    task automatic start_from_reset();
        reset = 1'b1;
        bus.Valid = 1'b0;
        bus.data_in = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Valid = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            compared++;
            if (sv !== 13'h0 || fld !== 48'h0) begin
                mismatched++;
                $display("FAIL reset c%0d: strobes=%h fields=%h required 0/0", c, sv, fld);
            end
        end
        reset = 1'b0;
        bus.Valid = 1'b0;
        tick();
        compared++;
        if (sv !== (FET | WA)) begin
            mismatched++;
            $display("FAIL reset_fetch: strobes=%h required %h", sv, FET | WA);
        end
        tick();
        compared++;
        if (sv !== REQ) begin
            mismatched++;
            $display("FAIL reset_imem: strobes=%h required %h", sv, REQ);
        end
    endtask

    task automatic test_alu_back_to_back();
        logic [12:0] exp [11] = '{FET|WA, REQ|INC, 0, WD, R_EN, FET|WA, REQ|INC, 0, WD, R_EN, FET|WA};
        bit          vld [11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        start_from_reset();
        for (int c = 0; c < 11; c++) begin
            bus.Valid = vld[c];
            bus.data_in = (c < 5) ? 32'h0022_0000 : 32'hC000_8001;
            #1;
            compared++;
            if (sv !== exp[c]) begin
                mismatched++;
                $display("FAIL alu c%0d: strobes=%h required %h", c, sv, exp[c]);
            end
            if (c == 2) begin
                compared++;
                if (fld !== {6'h00, 5'd1, 5'd2, 32'h0}) begin
                    mismatched++;
                    $display("FAIL alu_decode: fields=%h required %h", fld, {6'h00, 5'd1, 5'd2, 32'h0});
                end
            end
            if (c == 7) begin
                compared++;
                if (fld !== {6'h30, 5'd0, 5'd0, 32'hFFFF_8001}) begin
                    mismatched++;
                    $display("FAIL alu_lit_decode: fields=%h required %h", fld, {6'h30, 5'd0, 5'd0, 32'hFFFF_8001});
                end
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [12:0] exp [9] = '{FET|WA, REQ|INC, 0, WA, REQ, REQ, REQ, REQ|ST|R_EN, FET|WA};
        bit          vld [9] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
        start_from_reset();
        for (int c = 0; c < 9; c++) begin
            bus.Valid = vld[c];
            bus.data_in = (c < 4) ? 32'h4020_FFFC : 32'hDEAD_BEEF;
            #1;
            compared++;
            if (sv !== exp[c]) begin
                mismatched++;
                $display("FAIL load c%0d: strobes=%h required %h", c, sv, exp[c]);
            end
            if (c == 2 || c == 8) begin
                compared++;
                if (fld !== {6'h10, 5'd1, 5'd0, 32'hFFFF_FFFC}) begin
                    mismatched++;
                    $display("FAIL load_fields c%0d: fields=%h required %h", c, fld, {6'h10, 5'd1, 5'd0, 32'hFFFF_FFFC});
                end
            end
            tick();
        end
    endtask

    task automatic test_store();
        logic [12:0] exp [8] = '{FET|WA, REQ|INC, 0, WA, REQ|WE|DB, REQ|WE|DB, REQ|WE|DB, FET|WA};
        bit          vld [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
        start_from_reset();
        bus.data_in = 32'h4400_0000;
        for (int c = 0; c < 8; c++) begin
            bus.Valid = vld[c];
            #1;
            compared++;
            if (sv !== exp[c]) begin
                mismatched++;
                $display("FAIL store c%0d: strobes=%h required %h", c, sv, exp[c]);
            end
            tick();
        end
    endtask

    task automatic test_branch_halt();
        logic [12:0] exp [9] = '{FET|WA, REQ|INC, 0, BR|WA|PCL, REQ|INC, 0, 0, HLT, HLT};
        bit          vld [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
        start_from_reset();
        for (int c = 0; c < 9; c++) begin
            bus.Valid = vld[c];
            bus.data_in = (c < 3) ? 32'h8003_0000 : 32'hFC00_0000;
            #1;
            compared++;
            if (sv !== exp[c]) begin
                mismatched++;
                $display("FAIL branch_halt c%0d: strobes=%h required %h", c, sv, exp[c]);
            end
            if (c == 2 || c == 5) begin
                compared++;
                if (opcode !== ((c == 2) ? 6'h20 : 6'h3F)) begin
                    mismatched++;
                    $display("FAIL branch_halt_op c%0d: opcode=%h required %h", c, opcode, (c == 2) ? 6'h20 : 6'h3F);
                end
            end
            tick();
        end
        reset = 1'b1;
        bus.Valid = 1'b0;
        tick();
        reset = 1'b0;
        compared++;
        if (sv !== 13'h0) begin
            mismatched++;
            $display("FAIL halt_reset: strobes=%h required 0", sv);
        end
    endtask

    task automatic test_timeout();
        logic [12:0] e;
        start_from_reset();
        bus.data_in = 32'h0022_0000;
        for (int c = 0; c < 19; c++) begin
            bus.Valid = (c == 17);
            e = (c == 0) ? (FET | WA) : (c <= 15) ? REQ : TO;
            #1;
            compared++;
            if (sv !== e) begin
                mismatched++;
                $display("FAIL timeout c%0d: strobes=%h required %h", c, sv, e);
            end
            tick();
        end
    endtask

    task automatic test_timeout_edge();
        logic [12:0] e;
        start_from_reset();
        bus.data_in = 32'h0022_0000;
        for (int c = 0; c < 19; c++) begin
            bus.Valid = (c == 15);
            e = (c == 0) ? (FET | WA) : (c <= 14) ? REQ : (c == 15) ? (REQ | INC) :
                (c == 16) ? 13'h0 : (c == 17) ? WD : R_EN;
            #1;
            compared++;
            if (sv !== e) begin
                mismatched++;
                $display("FAIL timeout_edge c%0d: strobes=%h required %h", c, sv, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [12:0] exp [6] = '{FET|WA, REQ|INC, 0, WA, REQ, REQ};
        start_from_reset();
        bus.data_in = 32'h4000_0000;
        for (int c = 0; c < 6; c++) begin
            bus.Valid = (c == 1);
            #1;
            compared++;
            if (sv !== exp[c]) begin
                mismatched++;
                $display("FAIL mid_mem c%0d: strobes=%h required %h", c, sv, exp[c]);
            end
            if (c < 5) tick();
        end
        reset = 1'b1;
        bus.Valid = 1'b1;
        tick();
        reset = 1'b0;
        bus.Valid = 1'b0;
        compared++;
        if (sv !== 13'h0 || fld !== 48'h0) begin
            mismatched++;
            $display("FAIL mid_mem_reset: strobes=%h fields=%h required 0/0", sv, fld);
        end
        tick();
        compared++;
        if (sv !== (FET | WA)) begin
            mismatched++;
            $display("FAIL mid_mem_fetch: strobes=%h required %h", sv, FET | WA);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Valid = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_alu_back_to_back();
        test_load();
        test_store();
        test_branch_halt();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: simulation still running at %0t, required completion", $time);
        $fatal(1, "time limit");
    end

endmodule
